// File: rtl/seven_seg_scanner_pkg.sv
// Shared types, constants and BCD glyph decode for the 7-segment scanner.
// All segment values are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    DIG0, DIG1, DIG2, DIG3
  } dig_e;

  function automatic seg_t bcd2seg(bcd_t v);
    seg_t s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display bus between the stopwatch (master) and the scanner (slave).
// Ports: D_Q/BLINK toward the scanner; AN/SEG/DP back to the panel.
interface seven_seg_scanner_if;

  logic [16:1] D_Q;
  logic        BLINK;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  modport master (
    output D_Q, BLINK,
    input  AN, SEG, DP
  );

  modport slave (
    input  D_Q, BLINK,
    output AN, SEG, DP
  );

endinterface

// File: rtl/seven_seg_scanner_bcd_to_7seg.sv
// Combinational nibble to active-low glyph decoder.
// Ports: bcd_i nibble in, seg_o {g..a} out (A-F show a dash).
module bcd_to_7seg
  import seg_pkg::*;
(
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  assign seg_o = bcd2seg(bcd_i);

endmodule

// File: rtl/seven_seg_scanner.sv
// 4-digit multiplexed 7-seg driver with per-frame snapshot and colon blink.
// Ports: clk_in, RESET (async high), bus (slave: D_Q,BLINK in; AN,SEG,DP out).
// Option: LEADING_ZERO_BLANK_EN blanks digit3 when its nibble is zero.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input logic               clk_in,
  input logic               RESET,
  seven_seg_scanner_if.slave bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_q, pre_d;
  dig_e          idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          colon_q, colon_d;
  logic [3:0]    an_q, an_d;
  seg_t          seg_q, seg_d;
  logic          dp_q, dp_d;

  logic tick;
  logic frame;
  dig_e idx_nxt;
  bcd_t nib;
  seg_t glyph;
  seg_t seg_n;

  assign tick    = (pre_q == PRE_MAX);
  assign frame   = tick && (idx_q == DIG3);
  assign idx_nxt = dig_e'(idx_q + 2'd1);

  // Digit0 reads D_Q directly: the snapshot is taken on this same edge.
  always_comb begin
    nib = shadow_q[3:0];
    unique case (idx_nxt)
      DIG0: nib = bus.D_Q[4:1];
      DIG1: nib = shadow_q[7:4];
      DIG2: nib = shadow_q[11:8];
      DIG3: nib = shadow_q[15:12];
    endcase
  end

  bcd_to_7seg u_dec (
    .bcd_i (nib),
    .seg_o (glyph)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign seg_n = (idx_nxt == DIG3 && nib == 4'h0) ? SEG_BLANK : glyph;
`else
  assign seg_n = glyph;
`endif

  always_comb begin
    pre_d    = tick ? '0 : pre_q + PW'(1);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    an_d     = an_q;
    seg_d    = seg_q;
    dp_d     = dp_q;
    blink_d  = blink_q;
    colon_d  = colon_q;

    if (tick) begin
      idx_d = idx_nxt;
      an_d  = ~(4'b0001 << idx_nxt);
      seg_d = seg_n;
      dp_d  = ~((idx_nxt == DIG2) && colon_q);
    end

    if (frame) begin
      shadow_d = bus.D_Q;
    end

    if (!bus.BLINK) begin
      blink_d = '0;
      colon_d = 1'b1;
    end else if (frame) begin
      if (blink_q == BLK_MAX) begin
        blink_d = '0;
        colon_d = ~colon_q;
      end else begin
        blink_d = blink_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_in or posedge RESET) begin
    if (RESET) begin
      pre_q    <= '0;
      idx_q    <= DIG3;
      shadow_q <= 16'h0000;
      blink_q  <= '0;
      colon_q  <= 1'b1;
      an_q     <= AN_OFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      blink_q  <= blink_d;
      colon_q  <= colon_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.AN  = an_q;
  assign bus.SEG = seg_q;
  assign bus.DP  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (REFRESH_DIV=4, BLINK_FRAMES=2).
// Ports: none; drives the display bus through the interface master side.
module tb_seven_seg_scanner;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seven_seg_scanner_if bus_if ();

  seven_seg_scanner #(
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk_in (clk),
    .RESET  (rst),
    .bus    (bus_if.slave)
  );

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic slot();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Runs one full frame from digit3, checking digits 0..3.
  task automatic run_frame(input string tag, input logic [27:0] segs);
    logic [3:0] an_exp;
    for (int d = 0; d < 4; d++) begin
      slot();
      an_exp = ~(4'b0001 << d);
      chk({tag, "_an"}, 16'(bus_if.AN), 16'(an_exp));
      chk({tag, "_seg"}, 16'(bus_if.SEG), 16'(segs[d*7 +: 7]));
      chk({tag, "_dp"}, 16'(bus_if.DP), (d == 2) ? 16'd0 : 16'd1);
    end
  endtask

  initial begin
    logic [2:0] bexp;
    logic [6:0] lz_exp;
    logic [3:0] an1 [4];
    logic [6:0] sg1 [4];
    an1 = '{4'hE, 4'hD, 4'hB, 4'h7};
    sg1 = '{7'h19, 7'h30, 7'h24, 7'h79};
    bexp = 3'b100;
`ifdef LEADING_ZERO_BLANK_EN
    lz_exp = 7'h7F;
`else
    lz_exp = 7'h40;
`endif

    rst = 1'b1;
    bus_if.D_Q = 16'h1234;
    bus_if.BLINK = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 16'(bus_if.AN), 16'hF);
    chk("rst_seg", 16'(bus_if.SEG), 16'h7F);
    chk("rst_dp", 16'(bus_if.DP), 16'd1);

    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_an", 16'(bus_if.AN), 16'hF);
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      if (d > 0) slot();
      chk("scan_an", 16'(bus_if.AN), 16'(an1[d]));
      chk("scan_seg", 16'(bus_if.SEG), 16'(sg1[d]));
      chk("scan_dp", 16'(bus_if.DP), (d == 2) ? 16'd0 : 16'd1);
    end
    run_frame("f1234", {7'h79, 7'h24, 7'h30, 7'h19});

    slot();
    slot();
    chk("tear_d1", 16'(bus_if.SEG), 16'h30);
    bus_if.D_Q = 16'h4930;
    slot();
    chk("tear_d2", 16'(bus_if.SEG), 16'h24);
    slot();
    chk("tear_d3", 16'(bus_if.SEG), 16'h79);
    run_frame("f4930", {7'h19, 7'h10, 7'h30, 7'h40});

    bus_if.D_Q = 16'h10A5;
    run_frame("f10a5", {7'h79, 7'h40, 7'h3F, 7'h12});
    bus_if.D_Q = 16'h5555;
    run_frame("f5555", {7'h12, 7'h12, 7'h12, 7'h12});

    slot();
    bus_if.BLINK = 1'b1;
    for (int f = 0; f < 3; f++) begin
      slot();
      slot();
      chk("blink_dp", 16'(bus_if.DP), 16'(bexp[f]));
      if (f < 2) begin
        slot();
        slot();
      end
    end
    bus_if.BLINK = 1'b0;
    repeat (4) slot();
    chk("unblink_dp", 16'(bus_if.DP), 16'd0);

    bus_if.D_Q = 16'h0959;
    slot();
    chk("lz_old_d3", 16'(bus_if.SEG), 16'h12);
    slot();
    chk("lz_d0", 16'(bus_if.SEG), 16'h10);
    slot();
    slot();
    slot();
    chk("lz_an", 16'(bus_if.AN), 16'h7);
    chk("lz_seg", 16'(bus_if.SEG), 16'(lz_exp));

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_an", 16'(bus_if.AN), 16'hF);
    chk("mid_rst_seg", 16'(bus_if.SEG), 16'h7F);
    chk("mid_rst_dp", 16'(bus_if.DP), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_an", 16'(bus_if.AN), 16'hF);
    @(posedge clk);
    #1;
    chk("post_first_an", 16'(bus_if.AN), 16'hE);
    chk("post_first_seg", 16'(bus_if.SEG), 16'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
